// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, constants and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - round-robin picker: first set mask bit at or after ptr, wrapping
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] mask,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] rot;

    // Rotate the doubled mask so bit 0 is the requester at ptr, then scan from the far end
    // back toward 0 so the nearest set bit is the last one assigned.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        rot   = {mask, mask} >> ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                j = int'(ptr) + k;
                if (j >= NREQ) begin
                    j = j - NREQ;
                end
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter for one FIFO write port (optional FIFO_ARB_STATS_EN counters)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     fifo_cs,
    output logic                     fifo_wr_enb,
    output logic [WIDTH-1:0]         fifo_data_in,
    input  logic                     fifo_full,
    output logic                     busy,
    output logic [idx_w(NREQ)-1:0]   cur_owner
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]   stat_words,
    output logic [STAT_W-1:0]        stat_full_stall
`endif
);

    localparam int IW = idx_w(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic             en_q, en_d;

    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             can_write;
    logic             grant;
    logic [IW-1:0]    gidx;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .mask  (req_valid),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant selection: open search in IDLE, owner only in BURST; nothing while full or disabled.
    always_comb begin
        can_write = en_q & ~fifo_full;
        grant     = 1'b0;
        gidx      = owner_q;
        if (state_q == IDLE) begin
            grant = can_write & pick_found;
            gidx  = pick_idx;
        end else begin
            grant = can_write & req_valid[owner_q];
            gidx  = owner_q;
        end
    end

    // Write-port drive: the handshake and the FIFO write happen in the same cycle.
    always_comb begin
        req_ready    = grant ? (NREQ'(1) << gidx) : '0;
        fifo_wr_enb  = grant;
        fifo_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant && gidx == IW'(i)) begin
                fifo_data_in = req_data[i*WIDTH +: WIDTH];
            end
        end
        fifo_cs   = en_q;
        busy      = (state_q == BURST);
        cur_owner = owner_q;
    end

    // Next-state: a burst ends on req_last or when MAX_BURST words have gone through.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        en_d        = en;
        if (grant) begin
            if (state_q == IDLE) begin
                owner_d = gidx;
                if (req_last[gidx] || MAX_BURST == 1) begin
                    ptr_d = next_idx(gidx);
                end else begin
                    state_d     = BURST;
                    burst_cnt_d = BW'(1);
                end
            end else begin
                if (req_last[gidx] || (int'(burst_cnt_q) + 1 == MAX_BURST)) begin
                    state_d     = IDLE;
                    ptr_d       = next_idx(gidx);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            en_q        <= en_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] stat_words_q, stat_words_d;
    logic [STAT_W-1:0]      stat_full_stall_q, stat_full_stall_d;

    // Saturating per-requester word counters and full-stall cycle counter.
    always_comb begin
        stat_words_d      = stat_words_q;
        stat_full_stall_d = stat_full_stall_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] &&
                stat_words_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}) begin
                stat_words_d[i*STAT_W +: STAT_W] = stat_words_q[i*STAT_W +: STAT_W] + STAT_W'(1);
            end
        end
        if ((|req_valid) && fifo_full && en_q && stat_full_stall_q != {STAT_W{1'b1}}) begin
            stat_full_stall_d = stat_full_stall_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_words_q      <= '0;
            stat_full_stall_q <= '0;
        end else begin
            stat_words_q      <= stat_words_d;
            stat_full_stall_q <= stat_full_stall_d;
        end
    end

    assign stat_words      = stat_words_q;
    assign stat_full_stall = stat_full_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with a behavioural model
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_cs;
    logic                  fifo_wr_enb;
    logic [WIDTH-1:0]      fifo_data_in;
    logic                  fifo_full;
    logic                  busy;
    logic [1:0]            cur_owner;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*16-1:0]    stat_words;
    logic [15:0]           stat_full_stall;
`endif

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_cs      (fifo_cs),
        .fifo_wr_enb  (fifo_wr_enb),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .cur_owner    (cur_owner)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_words      (stat_words),
        .stat_full_stall (stat_full_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Behavioural model: who holds the port, how many words it has sent, where the search starts.
    bit  m_en_q;
    int  m_ptr, m_lock, m_words, m_owner, m_stall;
    int  m_cnt[NREQ];

    // Requester scripts: each requester offers len words, base+0 .. base+len-1.
    int               len[NREQ];
    int               sent[NREQ];
    int               lmode[NREQ];
    logic [WIDTH-1:0] base[NREQ];

    // Observations from the latest step.
    int               last_w;
    logic [NREQ-1:0]  obs_ready;
    logic             obs_wr, obs_cs;
    logic [WIDTH-1:0] obs_data;

    task automatic model_reset();
        m_en_q = 0; m_ptr = 0; m_lock = -1; m_words = 0; m_owner = 0; m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    function automatic int model_winner();
        if (!m_en_q || fifo_full) return -1;
        if (m_lock >= 0) return req_valid[m_lock] ? m_lock : -1;
        for (int k = 0; k < NREQ; k++) begin
            int j = (m_ptr + k) % NREQ;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic step();
        int w;
        logic [NREQ-1:0]  exp_ready;
        logic [WIDTH-1:0] exp_data;
        #2;
        w         = model_winner();
        exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
        exp_data  = (w >= 0) ? req_data[w*WIDTH +: WIDTH] : '0;
        obs_ready = req_ready; obs_wr = fifo_wr_enb; obs_data = fifo_data_in; obs_cs = fifo_cs;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("fifo_wr_enb", fifo_wr_enb, (w >= 0));
        check_eq("fifo_data_in", fifo_data_in, exp_data);
        check_eq("busy", busy, (m_lock >= 0));
        check_eq("cur_owner", cur_owner, m_owner);
        check_eq("fifo_cs", fifo_cs, m_en_q);
        check_eq("wr_while_full", fifo_wr_enb & fifo_full, 0);
        if ((|req_valid) && fifo_full && m_en_q) m_stall++;
        last_w = w;
        @(posedge clk);
        if (w >= 0) begin
            m_cnt[w]++;
            m_owner = w;
            if (m_lock < 0) begin
                if (req_last[w] || MAX_BURST == 1) m_ptr = (w + 1) % NREQ;
                else begin m_lock = w; m_words = 1; end
            end else begin
                m_words++;
                if (req_last[w] || m_words == MAX_BURST) begin
                    m_lock = -1;
                    m_ptr  = (w + 1) % NREQ;
                end
            end
        end
        m_en_q = en;
        #1;
    endtask

    task automatic clear_drv();
        for (int i = 0; i < NREQ; i++) begin
            len[i] = 0; sent[i] = 0; lmode[i] = 1; base[i] = WIDTH'(8'h10 * (i + 1));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (sent[i] < len[i]);
            req_data[i*WIDTH +: WIDTH] = base[i] + WIDTH'(sent[i]);
            req_last[i] = req_valid[i] && lmode[i] == 1 && sent[i] == len[i] - 1;
        end
    endtask

    task automatic tick();
        drive();
        step();
        if (last_w >= 0) sent[last_w]++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        int accepted;
        model_reset();
        clear_drv();

        // Reset with inputs active: everything quiet.
        rst = 1'b0; en = 1'b1; fifo_full = 1'b0;
        req_valid = '1; req_last = '1; req_data = '1;
        #3;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_wr", fifo_wr_enb, 0);
        check_eq("rst_data", fifo_data_in, 0);
        check_eq("rst_cs", fifo_cs, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_owner", cur_owner, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0; req_last = '0;

        // fifo_cs follows en one cycle later; no write without valid.
        step();
        step();
        check_eq("cs_after_en", obs_cs, 1);
        check_eq("no_valid_no_write", obs_wr, 0);

        // All requesters with single-word packets: plain rotation.
        req_valid = '1; req_last = '1;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(8'hA0 + i);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("rr_ready", obs_ready, 32'(4'b0001 << (k % 4)));
            check_eq("rr_data", obs_data, 32'h0A0 + k % 4);
        end

        // req1 sends a 3-word packet while req2 waits.
        clear_drv();
        len[1] = 3; len[2] = 1;
        seq = {};
        for (int k = 0; k < 4; k++) begin tick(); seq.push_back(last_w); end
        check_eq("pkt3_seq", {seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}, 32'h01010102);

        // req0 streams without last: bursts cap at MAX_BURST and req3 slips in between.
        clear_drv();
        len[0] = 8; lmode[0] = 0;
        seq = {};
        tick(); seq.push_back(last_w);
        len[3] = 1;
        for (int k = 0; k < 8; k++) begin tick(); seq.push_back(last_w); end
        check_eq("burst_cap_seq_a", {seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}, 32'h0);
        check_eq("burst_cap_seq_b", {seq[4][7:0], seq[5][7:0], seq[6][7:0], seq[7][7:0]}, 32'h03000000);
        check_eq("burst_cap_seq_c", seq[8], 0);

        // FIFO full mid-burst holds the word until full drops.
        clear_drv();
        len[1] = 4; len[2] = 2;
        tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("full_no_ready", obs_ready, 0);
            check_eq("full_no_wr", obs_wr, 0);
        end
        fifo_full = 1'b0;
        tick();
        check_eq("full_resume_data", obs_data, 32'h21);
        for (int k = 0; k < 5; k++) tick();

        // Depth-16 FIFO with 20 words offered: only 16 get in.
        clear_drv();
        for (int i = 0; i < NREQ; i++) len[i] = 5;
        accepted = 0;
        for (int k = 0; k < 60; k++) begin
            fifo_full = (accepted >= 16);
            tick();
            if (obs_wr) accepted++;
        end
        check_eq("fifo16_accepted", accepted, 16);
        fifo_full = 1'b0;

        // Reset in the middle of a burst.
        clear_drv();
        for (int i = 0; i < NREQ; i++) begin len[i] = 3; lmode[i] = 0; end
        for (int k = 0; k < 10 && m_lock < 0; k++) tick();
        check_eq("in_burst_before_rst", busy, 1);
        #2; rst = 1'b0; #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_owner", cur_owner, 0);
        check_eq("midrst_ready", req_ready, 0);
        check_eq("midrst_cs", fifo_cs, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        clear_drv();
        for (int i = 0; i < NREQ; i++) len[i] = 1;
        last_w = -1;
        for (int k = 0; k < 4 && last_w < 0; k++) tick();
        check_eq("ptr_zero_after_rst", last_w, 0);

        // en dropped for two cycles mid-burst: same owner continues.
        clear_drv();
        len[2] = 4; len[3] = 1;
        seq = {};
        tick(); seq.push_back(last_w);
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin tick(); if (last_w >= 0) seq.push_back(last_w); end
        en = 1'b1;
        for (int k = 0; k < 12 && seq.size() < 5; k++) begin tick(); if (last_w >= 0) seq.push_back(last_w); end
        check_eq("en_drop_len", seq.size(), 5);
        if (seq.size() == 5)
            check_eq("en_drop_seq", {seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0], seq[4][3:0]}, 32'h22223);

        // Randomized traffic with random full and enable.
        clear_drv();
        for (int c = 0; c < 500; c++) begin
            en        = ($urandom_range(0, 19) != 0);
            fifo_full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (sent[i] >= len[i] && $urandom_range(0, 1) == 1) begin
                    len[i]   = $urandom_range(1, 6);
                    sent[i]  = 0;
                    lmode[i] = $urandom_range(0, 1);
                    base[i]  = WIDTH'($urandom);
                end
            end
            tick();
        end

`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check_eq("stat_words", stat_words[i*16 +: 16], m_cnt[i]);
        check_eq("stat_full_stall", stat_full_stall, m_stall);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous_fifo write port between NREQ requesters. Drives the FIFO's cs, wr_enb and data_in, and backpressures requesters from full. Supports packet bursts: the winner keeps the port until it flags req_last or reaches MAX_BURST words. Sits directly in front of synchronous_fifo; the read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width; equals the FIFO WIDTH
MAX_BURST, 4, maximum words per grant (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
en  in  1  arbiter enable
req_valid  in  NREQ  per-requester word valid
req_last  in  NREQ  per-requester last word of packet
req_data  in  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
req_ready  out  NREQ  one-hot-or-zero accept; handshake = valid & ready
fifo_cs  out  1  FIFO chip select
fifo_wr_enb  out  1  FIFO write enable
fifo_data_in  out  WIDTH  FIFO write data
fifo_full  in  1  FIFO full flag
busy  out  1  arbiter in BURST state
cur_owner  out  $clog2(NREQ)  index of last/current grantee

Behaviour:
- Reset (rst=0, async): state=IDLE, ptr=0, owner=0, burst_cnt=0, en_q=0. Outputs: fifo_cs=0, req_ready=0, fifo_wr_enb=0, fifo_data_in=0, busy=0, cur_owner=0.
- fifo_cs = en_q, where en_q is en registered (1-cycle latency). A write requires fifo_cs=1.
- Grants are combinational on current inputs. A write occurs in the same cycle as the handshake: fifo_wr_enb=|req_ready, fifo_data_in=req_data of the granted requester, and 0 when idle.
- No grant is issued while fifo_full=1 or en_q=0. fifo_wr_enb & fifo_full must never be 1 together.
- IDLE:
  - winner = first i with req_valid[i], searching cyclically from ptr.
  - On grant, if req_last[winner]=1 or MAX_BURST==1: stay in IDLE, ptr<=winner+1 mod NREQ.
  - Otherwise: go to BURST, owner<=winner, burst_cnt<=1.
- BURST:
  - Only owner can be granted; all other requesters are blocked.
  - If owner req_valid=0: stall with no write and state held. There is no timeout.
  - On owner write: if req_last or burst_cnt+1==MAX_BURST, go to IDLE with ptr<=owner+1 mod NREQ. Otherwise burst_cnt++.
- Stall on full or en_q=0: no write, all state held (including mid-burst).
- ptr wraps from NREQ-1 to 0. cur_owner = owner in BURST, otherwise the last winner.
- Reset asserted mid-burst: returns immediately to IDLE with ptr=0. Partial packets are not flushed from the FIFO.
- Requester contract: req_data and req_last are held stable while valid & !ready.

Optional Feature:
Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds output stat_words[NREQ*16]: per-requester accepted-word counters, saturating at 0xFFFF.
  - Adds output stat_full_stall[16]: counts cycles with any req_valid & fifo_full & en_q, saturating.
  - All counters clear on reset.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state enum {IDLE, BURST}
  - STAT_W=16
  - function idx_w(n) returning the $clog2 index width
- Sub-module rr_pick (combinational): inputs mask[NREQ] and ptr; outputs found and idx. The winner is the first set bit at or after ptr, wrapping.

Test Plan:
1. Reset, then rst=1 and en=1 → all outputs 0 during reset; fifo_cs=1 one cycle after en; no write with req_valid=0.
2. NREQ=4, all valid, req_last=1111, req_data[i]=0xA0+i, fifo_full=0 → writes A0,A1,A2,A3,A0 on consecutive cycles; req_ready one-hot 0001,0010,0100,1000,0001.
3. req1 sends 3 words (last on 3rd) while req2 valid → three back-to-back req1 writes, busy=1 until the 3rd word, then req2 is written next cycle.
4. MAX_BURST=4, req0 sends 6 words with no last, req3 valid → 4 req0 words, 1 req3 word, then req0 resumes with words 5-6.
5. fifo_full=1 for 3 cycles mid-burst with req2 valid → req_ready=0 and fifo_wr_enb=0; the same data is written when full drops. Connected to synchronous_fifo DEPTH=16 with 20 words offered: 16 accepted, and fifo_wr_enb&full never seen.
6. Reset asserted mid-burst, or en dropped for 2 cycles → reset: busy=0 and ptr=0 immediately; en drop: the burst stalls and then continues with the same owner. With FIFO_ARB_STATS_EN defined, stat_words matches the scoreboard counts.
